// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//
// Write-side front end for a three-read/one-write register file. Pipeline
// writebacks arrive through a valid/ready handshake and are queued in an
// in-order FIFO. The FIFO drains at most one entry per cycle onto the
// register file write port. Values that are queued but not yet committed
// are forwarded onto the three read ports, so readers always see the
// youngest value.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_valid/wr_ready       writeback handshake (wr_ready = !full)
//   wr_addr, wr_data        writeback destination and value
//   drain_en                allows the head entry to commit this cycle
//   RW, PW, LE              register file write select/data/enable
//   RA, RB, RD              read selects from decode
//   PA_rf, PB_rf, PD_rf     raw register file read data
//   PA, PB, PD              forwarded read data
//   count, full, empty      queue occupancy and status
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic                       drain_en,
  output logic [AW-1:0]              RW,
  output logic [DW-1:0]              PW,
  output logic                       LE,
  input  logic [AW-1:0]              RA,
  input  logic [AW-1:0]              RB,
  input  logic [AW-1:0]              RD,
  input  logic [DW-1:0]              PA_rf,
  input  logic [DW-1:0]              PB_rf,
  input  logic [DW-1:0]              PD_rf,
  output logic [DW-1:0]              PA,
  output logic [DW-1:0]              PB,
  output logic [DW-1:0]              PD,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);

  // Queue storage and pointers
  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // Last committed entry, shown on RW/PW while the queue is empty
  logic [AW-1:0]   last_addr_q;
  logic [DW-1:0]   last_data_q;

  logic            enq;
  logic            deq;

  // Read port bundling for the shared forwarding loop
  logic [AW-1:0]   rsel [3];
  logic [DW-1:0]   rfd  [3];
  logic [DW-1:0]   fwd  [3];
  logic [PTRW-1:0] idx;

  // Status derived purely from registered occupancy
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = ~full;
  assign count    = count_q;
  assign LE       = ~empty & drain_en;

  // Writes to register 0 are accepted but never stored (hardwired zero)
  assign enq = wr_valid & wr_ready & (wr_addr != '0);
  assign deq = LE;

  assign RW = empty ? last_addr_q : addr_q[head_q];
  assign PW = empty ? last_data_q : data_q[head_q];

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d = tail_q + PTRW'(1);
    end
    if (deq) begin
      head_d = head_q + PTRW'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) begin
        addr_q[tail_q] <= wr_addr;
        data_q[tail_q] <= wr_data;
      end
      if (deq) begin
        last_addr_q <= addr_q[head_q];
        last_data_q <= data_q[head_q];
      end
    end
  end

  assign rsel[0] = RA;
  assign rsel[1] = RB;
  assign rsel[2] = RD;
  assign rfd[0]  = PA_rf;
  assign rfd[1]  = PB_rf;
  assign rfd[2]  = PD_rf;

  // Entries are walked oldest (head) to youngest so a later match
  // overrides an earlier one; the committing head still counts as valid
  // because the register file only captures it at the coming edge.
  always_comb begin
    idx = '0;
    for (int unsigned p = 0; p < 3; p++) begin
      fwd[p] = rfd[p];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head_q + PTRW'(i);
        if ((CW'(i) < count_q) && (addr_q[idx] == rsel[p])) begin
          fwd[p] = data_q[idx];
        end
      end
      if (rsel[p] == '0) begin
        fwd[p] = '0;
      end
    end
  end

  assign PA = fwd[0];
  assign PB = fwd[1];
  assign PD = fwd[2];

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          drain_en;
  logic [AW-1:0] RW;
  logic [DW-1:0] PW;
  logic          LE;
  logic [AW-1:0] RA, RB, RD;
  logic [DW-1:0] PA_rf, PB_rf, PD_rf;
  logic [DW-1:0] PA, PB, PD;
  logic [CW-1:0] count;
  logic          full, empty;

  regfile_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .drain_en(drain_en),
    .RW(RW), .PW(PW), .LE(LE),
    .RA(RA), .RB(RB), .RD(RD),
    .PA_rf(PA_rf), .PB_rf(PB_rf), .PD_rf(PD_rf),
    .PA(PA), .PB(PB), .PD(PD),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Scoreboard of accepted-but-uncommitted writes, oldest first
  ent_t sb[$];
  // tb_rf: bench register file (entry 0 deliberately nonzero);
  // arch: architecturally visible value of every register
  logic [DW-1:0] tb_rf [32];
  logic [DW-1:0] arch  [32];

  int errors = 0;
  int checks = 0;
  int le_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int r = 0; r < 32; r++) arch[r] = tb_rf[r];
    arch[0] = '0;
  endtask

  // Drive one cycle's inputs, settle, and check everything the model predicts
  task automatic apply(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic de, input logic [AW-1:0] ra);
    logic exp_le;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    drain_en = de;
    RA = ra;
    RB = 5'd7;
    RD = 5'd1;
    PA_rf = tb_rf[RA];
    PB_rf = tb_rf[RB];
    PD_rf = tb_rf[RD];
    #1;
    exp_le = (sb.size() != 0) && de;
    if (LE === 1'b1) le_seen++;
    chk("le", 32'(LE), 32'(exp_le));
    if (exp_le) begin
      chk("rw", 32'(RW), 32'(sb[0].addr));
      chk("pw", PW, sb[0].data);
    end
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("wr_ready", 32'(wr_ready), 32'(sb.size() != DEPTH));
    chk("pa", PA, arch[RA]);
    chk("pb", PB, arch[RB]);
    chk("pd", PD, arch[RD]);
  endtask

  // Update the model for the coming edge, then move past it
  task automatic advance();
    logic le_m, acc;
    le_m = (sb.size() != 0) && drain_en;
    acc  = wr_valid && (sb.size() < DEPTH);
    if (le_m) begin
      tb_rf[sb[0].addr] = sb[0].data;
      void'(sb.pop_front());
    end
    if (acc && wr_addr != '0) begin
      sb.push_back('{addr: wr_addr, data: wr_data});
      arch[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          de;
    logic [AW-1:0] ra;
    logic          exp_le;
    logic [CW-1:0] exp_cnt;
    logic [DW-1:0] exp_pa;
    logic [DW-1:0] exp_pb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int c0;
    tbl[0]  = '{1'b1, 5'd3,  32'hA,  1'b0, 5'd3,  1'b0, 3'd0, 32'hA000_0003, 32'hA000_0007};
    tbl[1]  = '{1'b1, 5'd3,  32'hB,  1'b0, 5'd3,  1'b0, 3'd1, 32'h0000_000A, 32'hA000_0007};
    tbl[2]  = '{1'b1, 5'd7,  32'hC,  1'b0, 5'd3,  1'b0, 3'd2, 32'h0000_000B, 32'hA000_0007};
    tbl[3]  = '{1'b1, 5'd9,  32'hD,  1'b0, 5'd3,  1'b0, 3'd3, 32'h0000_000B, 32'h0000_000C};
    tbl[4]  = '{1'b1, 5'd11, 32'hEE, 1'b0, 5'd3,  1'b0, 3'd4, 32'h0000_000B, 32'h0000_000C};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd3,  1'b0, 3'd4, 32'h0000_000B, 32'h0000_000C};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  1'b1, 3'd4, 32'h0000_000B, 32'h0000_000C};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  1'b1, 3'd3, 32'h0000_000B, 32'h0000_000C};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  1'b1, 3'd2, 32'h0000_000B, 32'h0000_000C};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  1'b1, 3'd1, 32'h0000_000B, 32'h0000_000C};
    tbl[10] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  1'b0, 3'd0, 32'h0000_000B, 32'h0000_000C};
    tbl[11] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 1'b0, 3'd0, 32'hA000_000B, 32'h0000_000C};

    for (int r = 0; r < 32; r++) tb_rf[r] = 32'hA000_0000 | 32'(r);
    tb_rf[0] = 32'h55;
    model_reset();

    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; drain_en = 1'b1;
    RA = '0; RB = '0; RD = '0; PA_rf = '0; PB_rf = '0; PD_rf = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_le", 32'(LE), 32'd0);
    chk("rst_rw", 32'(RW), 32'd0);
    chk("rst_pw", PW, 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write, one-cycle commit latency, no visibility gap
    apply(1'b1, 5'd5, 32'h14, 1'b1, 5'd5);
    advance();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    chk("lat_le", 32'(LE), 32'd1);
    chk("lat_rw", 32'(RW), 32'd5);
    chk("lat_pw", PW, 32'h14);
    advance();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    chk("lat_pa_rf", PA, 32'h14);
    chk("lat_count", 32'(count), 32'd0);
    advance();

    // Fill with drain frozen, then drain in order
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].de, tbl[i].ra);
      chk($sformatf("tbl%0d_le", i), 32'(LE), 32'(tbl[i].exp_le));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_pa", i), PA, tbl[i].exp_pa);
      chk($sformatf("tbl%0d_pb", i), PB, tbl[i].exp_pb);
      if (i == 4) chk("tbl_full_ready", 32'(wr_ready), 32'd0);
      advance();
    end

    // Write to register 0 is discarded; reads of 0 ignore the rf value
    apply(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    chk("zero_pa", PA, 32'd0);
    advance();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_le", 32'(LE), 32'd0);
    advance();

    // Sustained streaming: pointers wrap, occupancy stays at most 1
    c0 = le_seen;
    for (int i = 1; i <= 10; i++) begin
      apply(1'b1, 5'(i), 32'(19 + i), 1'b1, 5'(i - 1));
      chk("stream_cnt_le1", 32'(count > 3'd1), 32'd0);
      advance();
    end
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    advance();
    chk("stream_commits", 32'(le_seen - c0), 32'd10);

    // Asynchronous reset in the middle of a drain
    apply(1'b1, 5'd12, 32'h1200, 1'b0, 5'd12);
    advance();
    apply(1'b1, 5'd13, 32'h1300, 1'b0, 5'd12);
    advance();
    apply(1'b1, 5'd14, 32'h1400, 1'b0, 5'd12);
    advance();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    chk("mid_le_before", 32'(LE), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_le", 32'(LE), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_rw", 32'(RW), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_ready", 32'(wr_ready), 32'd1);
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    chk("post_pa", PA, 32'hA000_000C);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
